// File: rtl/slot_alloc_tracker_if.sv
// slot_alloc_tracker_if
//   Allocation/free handshake bundle between a slot requester (master) and
//   the slot tracker (slave).
//   alloc_req   : requester asks for one slot
//   alloc_ready : tracker accepts a request this cycle
//   alloc_valid : alloc_idx holds a granted slot
//   alloc_idx   : granted slot index
//   alloc_ack   : requester takes the grant
//   free_valid  : release the slot on free_idx
//   free_idx    : slot to release
interface slot_alloc_tracker_if #(
  parameter int IDX_W = 5
);
  logic             alloc_req;
  logic             alloc_ready;
  logic             alloc_valid;
  logic [IDX_W-1:0] alloc_idx;
  logic             alloc_ack;
  logic             free_valid;
  logic [IDX_W-1:0] free_idx;

  modport master (
    output alloc_req, alloc_ack, free_valid, free_idx,
    input  alloc_ready, alloc_valid, alloc_idx
  );

  modport slave (
    input  alloc_req, alloc_ack, free_valid, free_idx,
    output alloc_ready, alloc_valid, alloc_idx
  );
endinterface

// File: rtl/slot_alloc_tracker.sv
// slot_alloc_tracker
//   Tracks occupancy of the table slots and hands out free slot indices.
//   The registered free mask feeds an external lowest-set-bit priority
//   encoder whose result (pe_idx) is captured on each accepted allocation.
//
// Ports
//   clk             : clock, all state updates on the rising edge
//   rst             : synchronous active-high reset
//   flush           : release every slot and drop any pending grant
//   bus             : allocation/free handshake (slave side)
//   free_mask       : registered, bit i = 1 means slot i is free
//   pe_idx          : lowest set bit index of free_mask from the encoder
//   used_count      : number of allocated slots (0..NUM_SLOTS)
//   full / empty    : decoded from the registered used_count
//   err_double_free : one-cycle pulse when a free targets a free slot
module slot_alloc_tracker #(
  parameter int NUM_SLOTS = 32,
  parameter int IDX_W     = 5,
  parameter int CNT_W     = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  slot_alloc_tracker_if.slave  bus,
  output logic [NUM_SLOTS-1:0] free_mask,
  input  logic [IDX_W-1:0]     pe_idx,
  output logic [CNT_W-1:0]     used_count,
  output logic                 full,
  output logic                 empty,
  output logic                 err_double_free
);

  localparam logic [0:0] ST_READY = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]           state;
  logic [IDX_W-1:0]     idx_q;
  logic                 accept;
  logic                 free_ok;
  logic                 dbl_free;
  logic [NUM_SLOTS-1:0] mask_nxt;
  logic [CNT_W-1:0]     count_nxt;

  assign full  = (used_count == CNT_W'(NUM_SLOTS));
  assign empty = (used_count == '0);

  assign bus.alloc_ready = (state == ST_READY) && !full;
  assign bus.alloc_valid = (state == ST_GRANT);
  assign bus.alloc_idx   = idx_q;

  assign accept = bus.alloc_req && bus.alloc_ready;

  // A free aimed at a slot whose mask bit is already set is an error and has
  // no effect. Because pe_idx always points at a set bit, a free that names
  // the slot being allocated this edge falls into this case, so the allocate
  // and free never touch the same mask bit.
  assign dbl_free = bus.free_valid &&  free_mask[bus.free_idx];
  assign free_ok  = bus.free_valid && !free_mask[bus.free_idx];

  always_comb begin
    mask_nxt = free_mask;
    if (accept) begin
      mask_nxt[pe_idx] = 1'b0;
    end
    if (free_ok) begin
      mask_nxt[bus.free_idx] = 1'b1;
    end
  end

  always_comb begin
    count_nxt = used_count;
    unique case ({accept, free_ok})
      2'b10:   count_nxt = used_count + CNT_W'(1);
      2'b01:   count_nxt = used_count - CNT_W'(1);
      default: count_nxt = used_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_READY;
      idx_q           <= '0;
      free_mask       <= '1;
      used_count      <= '0;
      err_double_free <= 1'b0;
    end else if (flush) begin
      state           <= ST_READY;
      free_mask       <= '1;
      used_count      <= '0;
      err_double_free <= 1'b0;
    end else begin
      free_mask       <= mask_nxt;
      used_count      <= count_nxt;
      err_double_free <= dbl_free;
      if (accept) begin
        idx_q <= pe_idx;
      end
      unique case (state)
        ST_READY: if (accept)        state <= ST_GRANT;
        ST_GRANT: if (bus.alloc_ack) state <= ST_READY;
        default:                     state <= ST_READY;
      endcase
    end
  end

endmodule

// File: tb/tb_slot_alloc_tracker.sv
module tb_slot_alloc_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] free_mask;
  logic [4:0]  pe_idx;
  logic [5:0]  used_count;
  logic        full;
  logic        empty;
  logic        err_double_free;

  int checks = 0;
  int errors = 0;

  slot_alloc_tracker_if #(.IDX_W(5)) bus ();

  slot_alloc_tracker #(
    .NUM_SLOTS(32),
    .IDX_W(5),
    .CNT_W(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .bus(bus),
    .free_mask(free_mask),
    .pe_idx(pe_idx),
    .used_count(used_count),
    .full(full),
    .empty(empty),
    .err_double_free(err_double_free)
  );

  always #5 clk = ~clk;

  // downstream lowest-set-bit encoder, 0 when nothing is set
  always_comb begin
    pe_idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (free_mask[i]) pe_idx = 5'(i);
    end
  end

  // reference model: set of allocated slots plus the outstanding grant
  bit m_used [32];
  bit m_gnt;
  int m_gidx;
  bit m_err;

  function automatic int m_low();
    for (int i = 0; i < 32; i++) if (!m_used[i]) return i;
    return 0;
  endfunction

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < 32; i++) if (m_used[i]) c++;
    return c;
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] m;
    for (int i = 0; i < 32; i++) m[i] = !m_used[i];
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int c;
    c = m_cnt();
    chk("free_mask",  free_mask,           m_mask());
    chk("used_count", 32'(used_count),     32'(c));
    chk("full",       32'(full),           32'(c == 32));
    chk("empty",      32'(empty),          32'(c == 0));
    chk("ready",      32'(bus.alloc_ready), 32'(!m_gnt && c < 32));
    chk("valid",      32'(bus.alloc_valid), 32'(m_gnt));
    chk("idx",        32'(bus.alloc_idx),   32'(m_gidx));
    chk("dbl_free",   32'(err_double_free), 32'(m_err));
  endtask

  task automatic drive(input bit req, input bit ack, input bit fv, input int fidx,
                       input bit fl, input bit r);
    bus.alloc_req  = req;
    bus.alloc_ack  = ack;
    bus.free_valid = fv;
    bus.free_idx   = 5'(fidx);
    flush          = fl;
    rst            = r;
  endtask

  // advance one edge: model evaluates the rules on pre-edge state, then DUT compared
  task automatic tick();
    int  low;
    bit  ready, acc, fok;
    int  fi;
    fi = int'(bus.free_idx);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_used[i] = 0;
      m_gnt = 0; m_gidx = 0; m_err = 0;
    end else if (flush) begin
      for (int i = 0; i < 32; i++) m_used[i] = 0;
      m_gnt = 0; m_err = 0;
    end else begin
      low   = m_low();
      ready = !m_gnt && (m_cnt() < 32);
      acc   = bus.alloc_req && ready;
      fok   = bus.free_valid && m_used[fi];
      m_err = bus.free_valid && !m_used[fi];
      if (m_gnt && bus.alloc_ack) m_gnt = 0;
      if (acc) begin
        m_used[low] = 1; m_gidx = low; m_gnt = 1;
      end
      if (fok) m_used[fi] = 0;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic alloc_ack_pair();
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 0); tick();
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] mk;
    logic [4:0]  held;

    drive(0, 0, 0, 0, 0, 1);
    m_gnt = 0; m_gidx = 0; m_err = 0;
    @(negedge clk);
    do_reset();
    chk("rst_mask",  free_mask, 32'hFFFF_FFFF);
    chk("rst_ready", 32'(bus.alloc_ready), 32'd1);
    chk("rst_empty", 32'(empty), 32'd1);

    // three allocations, each acked next cycle
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 0, 0, 0); tick();
      chk("t1_idx", 32'(bus.alloc_idx), 32'(k));
      drive(0, 1, 0, 0, 0, 0); tick();
    end
    chk("t1_mask",  free_mask, 32'hFFFF_FFF8);
    chk("t1_count", 32'(used_count), 32'd3);
    chk("t1_empty", 32'(empty), 32'd0);

    // fill the table
    for (int k = 3; k < 32; k++) alloc_ack_pair();
    chk("t2_full",  32'(full), 32'd1);
    chk("t2_ready", 32'(bus.alloc_ready), 32'd0);
    // request while full alongside a free: not accepted this cycle
    drive(1, 0, 1, 17, 0, 0); tick();
    chk("t2_noacc", 32'(bus.alloc_valid), 32'd0);
    chk("t2_freed", 32'(free_mask), 32'h0002_0000);
    drive(1, 0, 0, 0, 0, 0); tick();
    chk("t2_idx17", 32'(bus.alloc_idx), 32'd17);
    drive(0, 1, 0, 0, 0, 0); tick();
    chk("t2_full2", 32'(full), 32'd1);

    // double free of slot 5
    do_reset();
    drive(0, 0, 1, 5, 0, 0); tick();
    chk("t3_err",   32'(err_double_free), 32'd1);
    chk("t3_mask",  free_mask, 32'hFFFF_FFFF);
    chk("t3_count", 32'(used_count), 32'd0);
    drive(0, 0, 0, 0, 0, 0); tick();
    chk("t3_pulse", 32'(err_double_free), 32'd0);

    // same-edge accept and free
    do_reset();
    for (int k = 0; k < 4; k++) alloc_ack_pair();
    drive(1, 0, 1, 2, 0, 0); tick();
    chk("t4_idx", 32'(bus.alloc_idx), 32'd4);
    mk = free_mask;
    chk("t4_bit2",  32'(mk[2]), 32'd1);
    chk("t4_count", 32'(used_count), 32'd4);
    drive(0, 1, 0, 0, 0, 0); tick();
    // free_idx equals the slot being granted: error, allocation still proceeds
    drive(1, 0, 1, 2, 0, 0); tick();
    chk("t4_pe_err", 32'(err_double_free), 32'd1);
    chk("t4_pe_idx", 32'(bus.alloc_idx), 32'd2);
    drive(0, 1, 0, 0, 0, 0); tick();

    // long hold in GRANT
    drive(1, 0, 0, 0, 0, 0); tick();
    held = bus.alloc_idx;
    for (int k = 0; k < 10; k++) begin
      drive(1, 0, 0, 0, 0, 0); tick();
      chk("t5_hold", 32'(bus.alloc_idx), 32'(held));
      chk("t5_nrdy", 32'(bus.alloc_ready), 32'd0);
    end
    drive(0, 1, 0, 0, 0, 0); tick();
    chk("t5_ready", 32'(bus.alloc_ready), 32'd1);

    // flush, then reset, in GRANT with 12 slots used
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      for (int k = 0; k < 11; k++) alloc_ack_pair();
      drive(1, 0, 0, 0, 0, 0); tick();
      chk("t6_pre", 32'(used_count), 32'd12);
      if (pass == 0) drive(1, 1, 1, 3, 1, 0);
      else           drive(1, 1, 1, 3, 0, 1);
      tick();
      chk("t6_valid", 32'(bus.alloc_valid), 32'd0);
      chk("t6_count", 32'(used_count), 32'd0);
      chk("t6_mask",  free_mask, 32'hFFFF_FFFF);
      chk("t6_ready", 32'(bus.alloc_ready), 32'd1);
    end

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 50),
            ($urandom_range(0, 99) < 30), int'($urandom_range(0, 31)),
            ($urandom_range(0, 199) == 0), ($urandom_range(0, 299) == 0));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
